// File: rtl/pipe_defs.sv
// Shared decode definitions: opcodes, IR field positions,
// opcode classes and the DE/EX latch layout.
package pipe_defs;

  localparam int PC_W   = 16;
  localparam int IR_W   = 32;
  localparam int DATA_W = 16;
  localparam int NREGS  = 16;
  localparam int REG_W  = $clog2(NREGS);

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_ADDI = 8'h02;
  localparam logic [7:0] OP_MOVI = 8'h03;
  localparam logic [7:0] OP_ST   = 8'h04;
  localparam logic [7:0] OP_BR   = 8'h10;
  localparam logic [7:0] OP_BRZ  = 8'h11;
  localparam logic [7:0] OP_NOP  = 8'hFF;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 24;
  localparam int DEST_HI = 23;
  localparam int DEST_LO = 20;
  localparam int SRC1_HI = 19;
  localparam int SRC1_LO = 16;
  localparam int SRC2_HI = 15;
  localparam int SRC2_LO = 12;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  function automatic logic is_branch(
    logic [7:0] op
  );
    return op inside {OP_BR, OP_BRZ};
  endfunction

  function automatic logic reads_src1(
    logic [7:0] op
  );
    return op inside {OP_ADD, OP_ADDI,
                      OP_ST, OP_BRZ};
  endfunction

  function automatic logic reads_src2(
    logic [7:0] op
  );
    return op inside {OP_ADD, OP_ST};
  endfunction

  function automatic logic writes_dest(
    logic [7:0] op
  );
    return op inside {OP_ADD, OP_ADDI,
                      OP_MOVI};
  endfunction

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [7:0]        opcode;
    reg_idx_t          dest;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] imm;
    logic              stall;
  } de_ex_t;

  localparam de_ex_t DE_EX_RESET = '{
    pc:     '0,
    opcode: OP_NOP,
    dest:   '0,
    src1:   '0,
    src2:   '0,
    imm:    '0,
    stall:  1'b1
  };

endpackage

// File: rtl/decode_stage_if.sv
// FE/DE, writeback and branch inputs plus DE/EX
// outputs of the decode stage.
interface decode_stage_if
  import pipe_defs::*;
#(
  parameter int PC_WIDTH   = PC_W,
  parameter int IR_WIDTH   = IR_W,
  parameter int DATA_WIDTH = DATA_W
);
  logic [PC_WIDTH-1:0]   I_PC;
  logic [IR_WIDTH-1:0]   I_IR;
  logic                  I_FetchStall;
  logic                  I_WBEnable;
  logic [3:0]            I_WBDestReg;
  logic [DATA_WIDTH-1:0] I_WBData;
  logic                  I_BranchResolved;
  logic [PC_WIDTH-1:0]   O_PC;
  logic [7:0]            O_Opcode;
  logic [3:0]            O_DestReg;
  logic [DATA_WIDTH-1:0] O_Src1Value;
  logic [DATA_WIDTH-1:0] O_Src2Value;
  logic [DATA_WIDTH-1:0] O_Imm;
  logic                  O_DecodeStall;
  logic                  O_BranchStallSignal;
  logic                  O_DepStallSignal;

  modport master (
    output I_PC, I_IR, I_FetchStall,
    output I_WBEnable, I_WBDestReg, I_WBData,
    output I_BranchResolved,
    input  O_PC, O_Opcode, O_DestReg,
    input  O_Src1Value, O_Src2Value, O_Imm,
    input  O_DecodeStall,
    input  O_BranchStallSignal, O_DepStallSignal
  );

  modport slave (
    input  I_PC, I_IR, I_FetchStall,
    input  I_WBEnable, I_WBDestReg, I_WBData,
    input  I_BranchResolved,
    output O_PC, O_Opcode, O_DestReg,
    output O_Src1Value, O_Src2Value, O_Imm,
    output O_DecodeStall,
    output O_BranchStallSignal, O_DepStallSignal
  );
endinterface

// File: rtl/decode_scoreboard.sv
// Busy-bit scoreboard: RAW/WAW hazard detect with
// same-cycle writeback bypass.
module decode_scoreboard
  import pipe_defs::*;
#(
  parameter int NUM_REGS = NREGS
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t src1,
  input  reg_idx_t src2,
  input  reg_idx_t dest,
  input  logic     rd1,
  input  logic     rd2,
  input  logic     wd,
  output logic     hazard,
  output logic     byp1,
  output logic     byp2
);
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] eff;
  logic                byp_d;

  always_comb begin
    clr_mask = '0;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  // a register written back this cycle is free now
  assign eff = busy & ~clr_mask;

  // set is applied last so it wins a same-bit clear
  always_comb begin
    busy_nxt = eff;
    if (set_en) busy_nxt[set_idx] = 1'b1;
  end

  always_ff @(negedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign byp1  = clr_en && clr_idx == src1;
  assign byp2  = clr_en && clr_idx == src2;
  assign byp_d = clr_en && clr_idx == dest;

  assign hazard = (rd1 && busy[src1] && !byp1)
               || (rd2 && busy[src2] && !byp2)
               || (wd  && busy[dest] && !byp_d);
endmodule

// File: rtl/decode_stage.sv
// Decode stage: field decode, register file read,
// hazard stalls and DE/EX latch.
module decode_stage
  import pipe_defs::*;
#(
  parameter int PC_WIDTH   = PC_W,
  parameter int IR_WIDTH   = IR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int NUM_REGS   = NREGS
) (
  input logic I_CLOCK,
  input logic I_RESET,
  decode_stage_if.slave bus
);
  logic [IR_WIDTH-1:0]   ir;
  logic [PC_WIDTH-1:0]   pc;
  logic [7:0]            op;
  reg_idx_t              dest, src1, src2;
  logic                  live, rd1, rd2, wd, br;
  logic                  sb_hazard, byp1, byp2;
  logic                  dep_hazard, issue;
  logic                  branch_pending;
  logic [DATA_WIDTH-1:0] src1_val, src2_val;
  logic [DATA_WIDTH-1:0] rf [NUM_REGS];
  de_ex_t                de_ex;

  assign ir   = bus.I_IR;
  assign pc   = bus.I_PC;
  assign op   = ir[OP_HI:OP_LO];
  assign dest = ir[DEST_HI:DEST_LO];
  assign src1 = ir[SRC1_HI:SRC1_LO];
  assign src2 = ir[SRC2_HI:SRC2_LO];

  assign live = !bus.I_FetchStall && op != OP_NOP;
  assign rd1  = reads_src1(op);
  assign rd2  = reads_src2(op);
  assign wd   = writes_dest(op);
  assign br   = is_branch(op);

  decode_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk     (I_CLOCK),
    .rst     (I_RESET),
    .set_en  (issue && wd),
    .set_idx (dest),
    .clr_en  (bus.I_WBEnable),
    .clr_idx (bus.I_WBDestReg),
    .src1    (src1),
    .src2    (src2),
    .dest    (dest),
    .rd1     (rd1),
    .rd2     (rd2),
    .wd      (wd),
    .hazard  (sb_hazard),
    .byp1    (byp1),
    .byp2    (byp2)
  );

  assign dep_hazard = live && !branch_pending
                   && sb_hazard;
  assign issue = live && !sb_hazard
              && !branch_pending;

  assign bus.O_DepStallSignal    = dep_hazard;
  assign bus.O_BranchStallSignal = branch_pending
    || (live && br && !dep_hazard);

  assign src1_val = byp1 ? bus.I_WBData : rf[src1];
  assign src2_val = byp2 ? bus.I_WBData : rf[src2];

  always_ff @(negedge I_CLOCK) begin
    if (bus.I_WBEnable)
      rf[bus.I_WBDestReg] <= bus.I_WBData;
  end

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      de_ex          <= DE_EX_RESET;
      branch_pending <= 1'b0;
    end else begin
      if (issue) begin
        de_ex.pc     <= pc;
        de_ex.opcode <= op;
        de_ex.dest   <= dest;
        de_ex.src1   <= src1_val;
        de_ex.src2   <= src2_val;
        de_ex.imm    <= ir[IMM_HI:IMM_LO];
        de_ex.stall  <= 1'b0;
      end else begin
        de_ex.opcode <= OP_NOP;
        de_ex.stall  <= 1'b1;
      end
      if (issue && br)
        branch_pending <= 1'b1;
      else if (bus.I_BranchResolved)
        branch_pending <= 1'b0;
    end
  end

  assign bus.O_PC          = de_ex.pc;
  assign bus.O_Opcode      = de_ex.opcode;
  assign bus.O_DestReg     = de_ex.dest;
  assign bus.O_Src1Value   = de_ex.src1;
  assign bus.O_Src2Value   = de_ex.src2;
  assign bus.O_Imm         = de_ex.imm;
  assign bus.O_DecodeStall = de_ex.stall;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage against a
// behavioural model of the decode/hazard rules.
module tb_decode_stage;
  import pipe_defs::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if bus ();

  decode_stage dut (
    .I_CLOCK (clk),
    .I_RESET (rst),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  bit          m_valid = 0;
  bit          m_bp = 0;
  bit          m_pend [int];
  logic [15:0] m_rf [16];
  logic [15:0] e_pc, e_s1, e_s2, e_imm;
  logic [7:0]  e_op;
  logic [3:0]  e_dest;
  logic        e_stall;
  logic        obs_dep, obs_br;

  task automatic check(string tag,
                       logic [31:0] obs,
                       logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic void classify(
    input  logic [7:0] op,
    output bit r1, output bit r2,
    output bit w,  output bit b);
    r1 = 0; r2 = 0; w = 0; b = 0;
    case (op)
      8'h01: begin r1 = 1; r2 = 1; w = 1; end
      8'h02: begin r1 = 1; w = 1; end
      8'h03: w = 1;
      8'h04: begin r1 = 1; r2 = 1; end
      8'h10: b = 1;
      8'h11: begin r1 = 1; b = 1; end
      default: ;
    endcase
  endfunction

  function automatic bit wb_hit(int r);
    return bus.I_WBEnable
        && int'(bus.I_WBDestReg) == r;
  endfunction

  function automatic bit busy(int r);
    return m_pend.exists(r) && !wb_hit(r);
  endfunction

  function automatic logic [15:0] rdval(int r);
    return wb_hit(r) ? bus.I_WBData : m_rf[r];
  endfunction

  task automatic cycle();
    logic [7:0] op;
    bit r1, r2, w, b, live, haz, iss;
    int d, s1, s2;
    logic [15:0] v1, v2;
    op = bus.I_IR[31:24];
    d  = int'(bus.I_IR[23:20]);
    s1 = int'(bus.I_IR[19:16]);
    s2 = int'(bus.I_IR[15:12]);
    classify(op, r1, r2, w, b);
    live = !bus.I_FetchStall && op != 8'hFF;
    haz = live && !m_bp &&
          ((r1 && busy(s1)) || (r2 && busy(s2))
           || (w && busy(d)));
    #1;
    obs_dep = bus.O_DepStallSignal;
    obs_br  = bus.O_BranchStallSignal;
    if (m_valid) begin
      check("dep_stall", obs_dep, haz);
      check("br_stall", obs_br,
            m_bp || (live && b && !haz));
    end
    @(negedge clk);
    v1 = rdval(s1);
    v2 = rdval(s2);
    if (bus.I_WBEnable)
      m_rf[bus.I_WBDestReg] = bus.I_WBData;
    if (rst) begin
      e_pc = 0; e_op = 8'hFF; e_dest = 0;
      e_s1 = 0; e_s2 = 0; e_imm = 0;
      e_stall = 1;
      m_pend.delete();
      m_bp = 0;
      m_valid = 1;
    end else begin
      iss = live && !haz && !m_bp;
      if (bus.I_WBEnable)
        m_pend.delete(int'(bus.I_WBDestReg));
      if (iss) begin
        e_pc = bus.I_PC; e_op = op;
        e_dest = 4'(d); e_s1 = v1; e_s2 = v2;
        e_imm = bus.I_IR[15:0]; e_stall = 0;
        if (w) m_pend[d] = 1;
        if (b) m_bp = 1;
      end else begin
        e_stall = 1; e_op = 8'hFF;
        if (bus.I_BranchResolved) m_bp = 0;
      end
    end
    #1;
    if (m_valid) begin
      check("pc", bus.O_PC, e_pc);
      check("opcode", bus.O_Opcode, e_op);
      check("dest", bus.O_DestReg, e_dest);
      check("src1", bus.O_Src1Value, e_s1);
      check("src2", bus.O_Src2Value, e_s2);
      check("imm", bus.O_Imm, e_imm);
      check("dstall", bus.O_DecodeStall, e_stall);
    end
    @(posedge clk);
  endtask

  task automatic put(logic [7:0] op, int d,
                     int s1, int s2);
    logic [11:0] lo;
    lo = 12'($urandom);
    bus.I_FetchStall = 0;
    bus.I_IR = {op, 4'(d), 4'(s1), 4'(s2), lo};
    bus.I_PC = bus.I_PC + 16'd1;
  endtask

  task automatic bubble();
    bus.I_FetchStall = 1;
    bus.I_IR = {8'hFF, 24'($urandom)};
  endtask

  task automatic wb(bit en, int r,
                    logic [15:0] data);
    bus.I_WBEnable = en;
    bus.I_WBDestReg = 4'(r);
    bus.I_WBData = data;
  endtask

  logic [7:0] ops [8];
  int q [$];

  initial begin
    ops = '{8'h01, 8'h02, 8'h03, 8'h04,
            8'h10, 8'h11, 8'hFF, 8'h77};
    rst = 1;
    bus.I_PC = 0;
    bus.I_BranchResolved = 0;
    wb(0, 0, 0);
    bubble();
    cycle();
    cycle();
    rst = 0;
    cycle();
    check("rst_dstall", bus.O_DecodeStall, 1);
    check("rst_op", bus.O_Opcode, 8'hFF);
    check("rst_dep", obs_dep, 0);
    check("rst_br", obs_br, 0);

    for (int i = 0; i < 16; i++) begin
      wb(1, i, 16'($urandom));
      cycle();
    end
    wb(0, 0, 0);

    // RAW on r3
    put(OP_ADD, 3, 1, 2);
    cycle();
    put(OP_ADD, 4, 3, 1);
    cycle();
    check("raw_stall", obs_dep, 1);
    cycle();
    check("raw_hold", bus.O_DecodeStall, 1);
    wb(1, 3, 16'h0055);
    cycle();
    check("raw_drop", obs_dep, 0);
    check("raw_byp", bus.O_Src1Value, 16'h0055);
    check("raw_issue", bus.O_DecodeStall, 0);
    bubble();
    wb(1, 4, 16'($urandom));
    cycle();

    // WAW on r5
    wb(0, 0, 0);
    put(OP_MOVI, 5, 0, 0);
    cycle();
    put(OP_MOVI, 5, 0, 0);
    cycle();
    check("waw_stall", obs_dep, 1);
    wb(1, 5, 16'h1234);
    cycle();
    check("waw_issue", bus.O_DecodeStall, 0);
    bubble();
    cycle();
    check("waw_once", bus.O_DecodeStall, 1);
    wb(0, 0, 0);

    // branch at 0x10
    put(OP_BR, 0, 0, 0);
    bus.I_PC = 16'h0010;
    cycle();
    check("br_pc", bus.O_PC, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      put(OP_ADD, 6, 1, 2);
      cycle();
      check("br_hold", obs_br, 1);
      check("br_bub", bus.O_DecodeStall, 1);
    end
    bus.I_BranchResolved = 1;
    cycle();
    check("br_disc", bus.O_DecodeStall, 1);
    bus.I_BranchResolved = 0;
    cycle();
    check("br_clear", obs_br, 0);
    check("br_next", bus.O_DecodeStall, 0);
    bubble();
    wb(1, 6, 16'($urandom));
    cycle();

    // set wins over same-cycle clear on r2
    put(OP_MOVI, 2, 0, 0);
    wb(1, 2, 16'h00AA);
    cycle();
    wb(0, 0, 0);
    put(OP_ADD, 7, 2, 1);
    cycle();
    check("sim_stall", obs_dep, 1);
    wb(1, 2, 16'h0BEE);
    cycle();
    check("sim_byp", bus.O_Src1Value, 16'h0BEE);
    bubble();
    wb(1, 7, 16'($urandom));
    cycle();
    wb(0, 0, 0);

    // reset while branch and r8 pending
    put(OP_MOVI, 8, 0, 0);
    cycle();
    put(OP_BR, 0, 0, 0);
    cycle();
    rst = 1;
    bubble();
    cycle();
    rst = 0;
    cycle();
    check("mr_dep", obs_dep, 0);
    check("mr_br", obs_br, 0);
    check("mr_dstall", bus.O_DecodeStall, 1);
    put(OP_ADD, 9, 8, 8);
    cycle();
    check("mr_free", obs_dep, 0);
    check("mr_issue", bus.O_DecodeStall, 0);
    bubble();
    wb(1, 9, 16'($urandom));
    cycle();

    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 4) == 0)
        bubble();
      else
        put(ops[$urandom_range(0, 7)],
            $urandom_range(0, 7),
            $urandom_range(0, 7),
            $urandom_range(0, 7));
      q.delete();
      foreach (m_pend[k]) q.push_back(k);
      if (rst)
        wb(0, 0, 0);
      else if (q.size() > 0
               && $urandom_range(0, 9) < 4)
        wb(1, q[$urandom_range(0, q.size()-1)],
           16'($urandom));
      else
        wb($urandom_range(0, 9) == 0,
           $urandom_range(0, 15), 16'($urandom));
      bus.I_BranchResolved = m_bp && !rst
        && ($urandom_range(0, 9) < 3);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
